// File: rtl/decoder_pkg.sv
// Shared types for the enable/grant decoder: FSM state encoding and width helpers.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  // Hold counter width: one spare bit so it can reach TIMEOUT-1 without wrapping.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational binary-to-one-hot decoder; all-zero output for indices >= WIDTH.
module decoder_onehot #(
  parameter int WIDTH = 8,
  parameter int EW    = $clog2(WIDTH)
) (
  input  logic [EW-1:0]    idx_i,
  output logic [WIDTH-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < WIDTH; i++)
      onehot_o[i] = (idx_i == EW'(i));
  end

endmodule

// File: rtl/decoder_enable_grant.sv
// Accepts an encoded request, holds a one-hot grant until ack or timeout,
// then spends one cooldown cycle before accepting again.
module decoder_enable_grant
  import decoder_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_enable,
  input  logic                     i_valid,
  input  logic [$clog2(WIDTH)-1:0] i_encode,
  output logic                     o_ready,
  input  logic                     i_ack,
  output logic [WIDTH-1:0]         o_grant,
  output logic                     o_busy,
  output logic                     o_timeout,
  output logic                     o_err
);

  localparam int EW = $clog2(WIDTH);
  localparam int CW = cnt_width(TIMEOUT);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] grant_q;
  logic             busy_q;
  logic             timeout_q;
  logic             err_q;
  logic [WIDTH-1:0] dec_onehot;
  logic             dec_hit;

  decoder_onehot #(.WIDTH(WIDTH), .EW(EW)) u_dec (
    .idx_i    (i_encode),
    .onehot_o (dec_onehot)
  );

  // An out-of-range index decodes to all-zero, so any set bit means in range.
  assign dec_hit = |dec_onehot;
  assign o_ready = i_enable && (state_q == IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (i_enable && i_valid) begin
            if (dec_hit) begin
              grant_q <= dec_onehot;
              busy_q  <= 1'b1;
              state_q <= GRANT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        GRANT: begin
          if (!i_enable) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (i_ack) begin
            // Ack wins over a coincident timeout: no timeout pulse.
            grant_q <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= COOLDOWN;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            grant_q   <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= COOLDOWN;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        COOLDOWN: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_grant   = grant_q;
  assign o_busy    = busy_q;
  assign o_timeout = timeout_q;
  assign o_err     = err_q;

endmodule
